// File: rtl/linebuf_window_ctrl.sv
// Sequencer for the two-row line buffer: handshakes the raster stream, tracks pixel position,
// flags complete 2x2 windows and frames each image. Optional macro: LBCTRL_PERF_EN (stall_cnt).
module linebuf_window_ctrl #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int STRIDE = 2,
  parameter int LB_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] lb_d_in,
  output logic              lb_in_valid,
  output logic              lb_clear,
  output logic              win_valid,
  output logic [15:0]       win_idx,
  output logic              busy,
  output logic              frame_done,
`ifdef LBCTRL_PERF_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DW = $clog2(LB_LAT + 1) + 1;

  state_t          state, state_next;
  logic [DW-1:0]   drain_cnt;
  logic [15:0]     row, col;
  logic [LB_LAT:0] win_sr;
  logic            accept, last_pix, win_cond;

  // Handshake: a pixel transfers in any cycle where s_valid and s_ready are both high;
  // s_ready depends only on state, so it never combinationally follows s_valid.
  assign s_ready    = (state == S_RUN);
  assign accept     = s_valid & s_ready;
  assign busy       = (state != S_IDLE);
  assign lb_clear   = (state == S_CLEAR);
  assign frame_done = (state == S_DONE);
  assign win_valid  = win_sr[LB_LAT];
  assign dbg_state  = state;

  assign last_pix = (row == 16'(IMG_H - 1)) && (col == 16'(IMG_W - 1));
  assign win_cond = (row != 16'd0) && (col != 16'd0) &&
                    ((STRIDE == 1) || (row[0] && col[0]));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CLEAR;
      S_CLEAR: state_next = S_RUN;
      S_RUN:   if (accept && last_pix) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt == DW'(LB_LAT)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_d_in     <= '0;
      lb_in_valid <= 1'b0;
    end else begin
      lb_in_valid <= accept;
      if (accept) lb_d_in <= s_data;
    end
  end

  // Window flag travels alongside the pixel through the line buffer latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      win_sr  <= '0;
      win_idx <= '0;
    end else if (state == S_CLEAR) begin
      row     <= '0;
      col     <= '0;
      win_sr  <= '0;
      win_idx <= '0;
    end else begin
      win_sr <= {win_sr[LB_LAT-1:0], accept & win_cond};
      if (win_valid) win_idx <= win_idx + 16'd1;
      if (accept) begin
        if (col == 16'(IMG_W - 1)) begin
          col <= '0;
          row <= row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
    end
  end

`ifdef LBCTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == S_CLEAR) begin
      stall_cnt <= '0;
    end else if ((state == S_RUN) && !s_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Directed bench for linebuf_window_ctrl: three 4x4 instances (S2/L1, S1/L1, S2/L3) share one stimulus.
module tb_linebuf_window_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] s_data;
  logic        s_valid;

  logic        s_ready_o[3];
  logic [31:0] lb_d_in_o[3];
  logic        lb_in_valid_o[3];
  logic        lb_clear_o[3];
  logic        win_valid_o[3];
  logic [15:0] win_idx_o[3];
  logic        busy_o[3];
  logic        frame_done_o[3];
  logic [2:0]  dbg_o[3];
`ifdef LBCTRL_PERF_EN
  logic [15:0] stall_o[3];
  int          stall_done[3];
`endif

  int cyc = 0;
  int checks, errors;
  int acc_cyc[16];
  int win_c[3][$];
  int win_i[3][$];
  int fd_c[3][$];
  int li_c[3][$];
  int li_d[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    linebuf_window_ctrl #(
      .DATA_W(32), .IMG_W(4), .IMG_H(4),
      .STRIDE((g == 1) ? 1 : 2),
      .LB_LAT((g == 2) ? 3 : 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready_o[g]), .lb_d_in(lb_d_in_o[g]), .lb_in_valid(lb_in_valid_o[g]),
      .lb_clear(lb_clear_o[g]), .win_valid(win_valid_o[g]), .win_idx(win_idx_o[g]),
      .busy(busy_o[g]), .frame_done(frame_done_o[g]),
`ifdef LBCTRL_PERF_EN
      .stall_cnt(stall_o[g]),
`endif
      .dbg_state(dbg_o[g])
    );
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 3; g++) begin
        if (win_valid_o[g]) begin
          win_c[g].push_back(cyc);
          win_i[g].push_back(int'(win_idx_o[g]));
        end
        if (frame_done_o[g]) fd_c[g].push_back(cyc);
        if (lb_in_valid_o[g]) begin
          li_c[g].push_back(cyc);
          li_d[g].push_back(int'(lb_d_in_o[g]));
        end
`ifdef LBCTRL_PERF_EN
        if (frame_done_o[g]) stall_done[g] = int'(stall_o[g]);
`endif
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_s_ready[%0d]", tag, g), 32'(s_ready_o[g]), 0);
      chk($sformatf("%s_lb_d_in[%0d]", tag, g), lb_d_in_o[g], 0);
      chk($sformatf("%s_lb_in_valid[%0d]", tag, g), 32'(lb_in_valid_o[g]), 0);
      chk($sformatf("%s_lb_clear[%0d]", tag, g), 32'(lb_clear_o[g]), 0);
      chk($sformatf("%s_win_valid[%0d]", tag, g), 32'(win_valid_o[g]), 0);
      chk($sformatf("%s_win_idx[%0d]", tag, g), 32'(win_idx_o[g]), 0);
      chk($sformatf("%s_busy[%0d]", tag, g), 32'(busy_o[g]), 0);
      chk($sformatf("%s_frame_done[%0d]", tag, g), 32'(frame_done_o[g]), 0);
      chk($sformatf("%s_state[%0d]", tag, g), 32'(dbg_o[g]), 0);
    end
  endtask

  // Drives one frame; the accept cycle of each pixel is taken from the bench's own schedule.
  task automatic run_frame(input bit toggle, input bit poke, input int n_pix);
    int p, k;
    for (int g = 0; g < 3; g++) begin
      win_c[g].delete(); win_i[g].delete(); fd_c[g].delete();
      li_c[g].delete();  li_d[g].delete();
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    chk("busy_at_start", 32'(busy_o[0]), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("lb_clear_after_start", 32'(lb_clear_o[0]), 1);
    chk("s_ready_in_clear", 32'(s_ready_o[0]), 0);
    p = 0;
    k = 0;
    while (p < n_pix) begin
      @(posedge clk); #1;
      start   = poke && (k == 5);
      s_valid = toggle ? ((k >= 16) || (k % 2 == 1)) : 1'b1;
      if (s_valid) begin
        s_data     = 32'(p);
        acc_cyc[p] = cyc;
        p++;
      end else begin
        s_data = $urandom;
      end
      if (k == 0) begin
        @(negedge clk);
        chk("s_ready_first_run", 32'(s_ready_o[0]), 1);
      end
      k++;
    end
    if (n_pix < 16) return;
    @(posedge clk); #1;
    s_valid = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    chk("s_ready_after_last", 32'(s_ready_o[0]), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = poke;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_done", 32'(busy_o[0]), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_done", 32'(dbg_o[0]), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_wins(input int g);
    int pix[$];
    int lat;
    lat = (g == 2) ? 3 : 1;
    if (g == 1) pix = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    else        pix = '{5, 7, 13, 15};
    chk($sformatf("win_count[%0d]", g), win_c[g].size(), pix.size());
    for (int i = 0; i < pix.size() && i < win_c[g].size(); i++) begin
      chk($sformatf("win_cycle[%0d][%0d]", g, i), win_c[g][i], acc_cyc[pix[i]] + 1 + lat);
      chk($sformatf("win_idx[%0d][%0d]", g, i), win_i[g][i], i);
    end
    chk($sformatf("frame_done_count[%0d]", g), fd_c[g].size(), 1);
    if (fd_c[g].size() > 0)
      chk($sformatf("frame_done_cycle[%0d]", g), fd_c[g][0], acc_cyc[15] + 2 + lat);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Frame with s_valid held high.
    run_frame(1'b0, 1'b0, 16);
    for (int g = 0; g < 3; g++) check_wins(g);
    chk("lb_stream_count", li_c[0].size(), 16);
    for (int i = 0; i < 16 && i < li_c[0].size(); i++) begin
      chk($sformatf("lb_d_in[%0d]", i), li_d[0][i], i);
      chk($sformatf("lb_in_valid_cycle[%0d]", i), li_c[0][i], acc_cyc[i] + 1);
    end
`ifdef LBCTRL_PERF_EN
    chk("stall_cnt_held", stall_done[0], 0);
`endif

    // Frame with 8 stall cycles early in RUN.
    run_frame(1'b1, 1'b0, 16);
    for (int g = 0; g < 3; g++) check_wins(g);
`ifdef LBCTRL_PERF_EN
    chk("stall_cnt_toggle", stall_done[0], 8);
`endif

    // Frame with start pulsed in RUN and in DONE.
    run_frame(1'b0, 1'b1, 16);
    for (int g = 0; g < 3; g++) check_wins(g);

    // Abort after pixel 9, then a clean frame.
    run_frame(1'b0, 1'b0, 10);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("lb_in_valid_pre_reset", 32'(lb_in_valid_o[0]), 1);
    chk("win_idx_pre_reset", 32'(win_idx_o[0]), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    for (int g = 0; g < 3; g++) chk($sformatf("aborted_frame_done[%0d]", g), fd_c[g].size(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0, 1'b0, 16);
    for (int g = 0; g < 3; g++) check_wins(g);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
